// File: rtl/fpu_dispatch_unit_pkg.sv
// ============================================================================
// Module  : fpu_dispatch_unit_pkg
// Brief   : Shared operation codes, FSM encodings and defaults for the FPU
//           dispatch stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_dispatch_unit_pkg;

    localparam logic [1:0] FPU_ADD  = 2'd0;
    localparam logic [1:0] FPU_SUB  = 2'd1;
    localparam logic [1:0] FPU_MUL  = 2'd2;
    localparam logic [1:0] FPU_SQRT = 2'd3;

    typedef logic [1:0] fpd_state_t;

    localparam fpd_state_t FPD_IDLE  = 2'd0;
    localparam fpd_state_t FPD_ISSUE = 2'd1;
    localparam fpd_state_t FPD_WAIT  = 2'd2;
    localparam fpd_state_t FPD_DONE  = 2'd3;

    localparam int FPD_TIMEOUT_CYCLES = 64;

endpackage

`default_nettype wire

// File: rtl/fpu_dispatch_fifo.sv
// ============================================================================
// Module  : fpu_dispatch_fifo
// Brief   : Small request FIFO; pointers carry one extra wrap bit so full and
//           empty are distinguishable. Head entry is presented combinationally.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_dispatch_fifo #(
    parameter int DATA_W = 71,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic [AW:0]       w_ptr_diff;

    assign w_ptr_diff = r_wptr ^ r_rptr;
    assign o_empty    = (r_wptr == r_rptr);
    assign o_full     = (w_ptr_diff == {1'b1, {AW{1'b0}}});
    assign o_data     = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wptr[AW-1:0]] <= i_data;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpu_dispatch_unit.sv
// ============================================================================
// Module  : fpu_dispatch_unit
// Brief   : Issue stage ahead of the fixed-point unit: buffers tagged requests,
//           drives one op at a time into the FPU and returns result plus tag.
//           Optional WAIT timeout enabled by macro FPU_DISPATCH_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_dispatch_unit
    import fpu_dispatch_unit_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TAG_W          = 5,
    parameter int DEPTH          = 2,
    parameter int TIMEOUT_CYCLES = FPD_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_operation,
    input  logic [WIDTH-1:0] in_operand_1,
    input  logic [WIDTH-1:0] in_operand_2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [WIDTH-1:0] fpu_operand_1,
    output logic [WIDTH-1:0] fpu_operand_2,
    output logic [1:0]       fpu_operation,
    input  logic [WIDTH-1:0] fpu_result,
    input  logic             fpu_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_error,
    output logic             busy
);

    localparam int PW = 2 * WIDTH + 2 + TAG_W;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("fpu_dispatch_unit: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    fpd_state_t       r_state;
    fpd_state_t       w_state_nxt;

    logic [WIDTH-1:0] r_fpu_op1;
    logic [WIDTH-1:0] r_fpu_op2;
    logic [1:0]       r_fpu_opc;
    logic [TAG_W-1:0] r_tag;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_result;
    logic [TAG_W-1:0] r_out_tag;

    logic             w_push;
    logic             w_pop;
    logic             w_capture;
    logic             w_release;
    logic             w_timeout;
    logic             w_full;
    logic             w_empty;
    logic [PW-1:0]    w_fifo_wdata;
    logic [PW-1:0]    w_fifo_rdata;

    assign in_ready     = !w_full;
    assign w_push       = in_valid && !w_full;
    assign w_fifo_wdata = {in_operation, in_operand_1, in_operand_2, in_tag};

    fpu_dispatch_fifo #(
        .DATA_W (PW),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_data  (w_fifo_wdata),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef FPU_DISPATCH_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_out_error;

    // Fires on the last permitted WAIT cycle, so DONE is reached after exactly TIMEOUT_CYCLES waits.
    assign w_timeout = (r_state == FPD_WAIT) && !fpu_ready &&
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt  <= '0;
            r_out_error <= 1'b0;
        end else begin
            if (r_state == FPD_ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == FPD_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_out_error <= 1'b1;
            end else if (w_release) begin
                r_out_error <= 1'b0;
            end
        end
    end

    assign out_error = r_out_error;
`else
    assign w_timeout = 1'b0;
    assign out_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FPD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FPD_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = FPD_ISSUE;
                end
            end
            // Single settle cycle: the FPU's ready still reflects the previous op here.
            FPD_ISSUE: begin
                w_state_nxt = FPD_WAIT;
            end
            FPD_WAIT: begin
                if (fpu_ready || w_timeout) begin
                    w_state_nxt = FPD_DONE;
                end
            end
            FPD_DONE: begin
                if (out_ready) begin
                    w_state_nxt = w_empty ? FPD_IDLE : FPD_ISSUE;
                end
            end
            default: begin
                w_state_nxt = FPD_IDLE;
            end
        endcase
    end

    always_comb begin
        w_pop     = 1'b0;
        w_capture = 1'b0;
        w_release = 1'b0;
        case (r_state)
            FPD_IDLE: begin
                w_pop = !w_empty;
            end
            FPD_WAIT: begin
                w_capture = fpu_ready;
            end
            FPD_DONE: begin
                w_release = out_ready;
                w_pop     = out_ready && !w_empty;
            end
            default: begin
                w_pop = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fpu_op1    <= '0;
            r_fpu_op2    <= '0;
            r_fpu_opc    <= '0;
            r_tag        <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_tag    <= '0;
        end else begin
            if (w_pop) begin
                {r_fpu_opc, r_fpu_op1, r_fpu_op2, r_tag} <= w_fifo_rdata;
            end
            if (w_capture) begin
                r_out_valid  <= 1'b1;
                r_out_result <= fpu_result;
                r_out_tag    <= r_tag;
            end else if (w_timeout) begin
                r_out_valid  <= 1'b1;
                r_out_result <= '1;
                r_out_tag    <= r_tag;
            end else if (w_release) begin
                r_out_valid  <= 1'b0;
            end
        end
    end

    assign fpu_operand_1 = r_fpu_op1;
    assign fpu_operand_2 = r_fpu_op2;
    assign fpu_operation = r_fpu_opc;
    assign out_valid     = r_out_valid;
    assign out_result    = r_out_result;
    assign out_tag       = r_out_tag;
    assign busy          = !w_empty || (r_state != FPD_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fpu_dispatch_unit.sv
// ============================================================================
// Module  : tb_fpu_dispatch_unit
// Brief   : Scoreboard bench for fpu_dispatch_unit with a behavioural Q22.10
//           FPU model. Exercises timeout path when FPU_DISPATCH_TIMEOUT_EN is set.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_dispatch_unit;
    import fpu_dispatch_unit_pkg::*;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    localparam int DEPTH = 2;
    localparam int TMO   = 8;
    localparam int FBITS = 10;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_operation = 2'd0;
    logic [WIDTH-1:0] in_operand_1 = '0;
    logic [WIDTH-1:0] in_operand_2 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [WIDTH-1:0] fpu_operand_1;
    logic [WIDTH-1:0] fpu_operand_2;
    logic [1:0]       fpu_operation;
    logic [WIDTH-1:0] fpu_result;
    logic             fpu_ready;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_error;
    logic             busy;

    always #5 clk = ~clk;

    fpu_dispatch_unit #(
        .WIDTH          (WIDTH),
        .TAG_W          (TAG_W),
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_operation  (in_operation),
        .in_operand_1  (in_operand_1),
        .in_operand_2  (in_operand_2),
        .in_tag        (in_tag),
        .fpu_operand_1 (fpu_operand_1),
        .fpu_operand_2 (fpu_operand_2),
        .fpu_operation (fpu_operation),
        .fpu_result    (fpu_result),
        .fpu_ready     (fpu_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_tag       (out_tag),
        .out_error     (out_error),
        .busy          (busy)
    );

    // Fixed-point arithmetic from first principles: Q22.10 add/sub/mul, unsigned sqrt.
    function automatic logic [31:0] fx_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint    p;
        logic [63:0] pv;
        longint    x;
        longint    r;
        longint    t;
        case (op)
            FPU_ADD: return a + b;
            FPU_SUB: return a - b;
            FPU_MUL: begin
                p  = longint'($signed(a)) * longint'($signed(b));
                pv = p;
                return pv[FBITS+31:FBITS];
            end
            default: begin
                x = longint'({a, 10'b0});
                r = 0;
                for (int bp = 20; bp >= 0; bp--) begin
                    t = r | (longint'(1) << bp);
                    if (t * t <= x) r = t;
                end
                return r[31:0];
            end
        endcase
    endfunction

    // FPU model: result/ready follow the operands registered at the last edge, so
    // in the first cycle after new operands both still describe the previous op.
    logic [1:0]  m_op = 2'd0;
    logic [31:0] m_a  = '0;
    logic [31:0] m_b  = '0;
    int          m_cnt = 0;
    int          mul_delay = 0;
    bit          never_ready = 1'b0;

    always @(posedge clk) begin
        if ({fpu_operation, fpu_operand_1, fpu_operand_2} != {m_op, m_a, m_b}) begin
            m_op  <= fpu_operation;
            m_a   <= fpu_operand_1;
            m_b   <= fpu_operand_2;
            m_cnt <= 0;
        end else if (m_cnt < 1000000) begin
            m_cnt <= m_cnt + 1;
        end
    end

    assign fpu_result = fx_calc(m_op, m_a, m_b);
    assign fpu_ready  = !never_ready &&
                        (m_cnt >= ((m_op == FPU_ADD || m_op == FPU_SUB) ? 0 : mul_delay));

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got result 0x%0h tag %0d, expected nothing (t=%0t)",
                         out_result, out_tag, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_result", out_result, e.res);
                check("sb_tag", 32'(out_tag), 32'(e.tag));
                check("sb_error", 32'(out_error), 32'(e.err));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input bit expect_out);
        bit acc;
        exp_t e;
        in_valid     = 1'b1;
        in_operation = op;
        in_operand_1 = a;
        in_operand_2 = b;
        in_tag       = tag;
        acc          = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: tag %0d not accepted within 200 cycles, expected acceptance", tag);
        end else if (expect_out) begin
            e.res = fx_calc(op, a, b);
            e.tag = tag;
            e.err = 1'b0;
            q.push_back(e);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && q.size() != 0; i++) tick(1);
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
        end
        tick(3);
    endtask

    bit rand_ready_en = 1'b0;

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fpu_op1", fpu_operand_1, 32'd0);
        check("rst_fpu_op2", fpu_operand_2, 32'd0);
        check("rst_fpu_opc", 32'(fpu_operation), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_out_error", 32'(out_error), 32'd0);
        tick(1);

        // ADD latency: accepted at E, fpu_* after E+1, out_valid after E+3
        send(FPU_ADD, 32'h600, 32'h900, 5'd3, 1'b1);
        tick(1);
        check("add_fpu_opc", 32'(fpu_operation), 32'(FPU_ADD));
        check("add_fpu_op1", fpu_operand_1, 32'h600);
        check("add_fpu_op2", fpu_operand_2, 32'h900);
        check("add_valid_e1", 32'(out_valid), 32'd0);
        tick(1);
        check("add_valid_e2", 32'(out_valid), 32'd0);
        check("add_fpu_opc_wait", 32'(fpu_operation), 32'(FPU_ADD));
        tick(1);
        check("add_valid_e3", 32'(out_valid), 32'd1);
        check("add_result", out_result, 32'hF00);
        check("add_tag", 32'(out_tag), 32'd3);
        wait_drain();

        // MUL after a ready ADD: stale ready must not be captured
        mul_delay = 5;
        send(FPU_MUL, 32'h800, 32'hC00, 5'd4, 1'b1);
        tick(3);
        check("mul_no_stale", 32'(out_valid), 32'd0);
        check("mul_fpu_opc", 32'(fpu_operation), 32'(FPU_MUL));
        wait_drain();

        // Backpressure across FIFO wrap
        out_ready = 1'b0;
        send(FPU_SUB, 32'h1000, 32'h400, 5'd1, 1'b1);
        send(FPU_SUB, 32'h2000, 32'h100, 5'd2, 1'b1);
        send(FPU_SUB, 32'h0100, 32'h300, 5'd3, 1'b1);
        @(negedge clk);
        check("bp_in_ready_full", 32'(in_ready), 32'd0);
        tick(10);
        @(negedge clk);
        check("bp_in_ready_hold", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_out_tag", 32'(out_tag), 32'd1);
        check("bp_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();
        check("bp_in_ready_after", 32'(in_ready), 32'd1);

        // Randomised traffic with random writeback backpressure
        mul_delay     = $urandom_range(0, 4);
        rand_ready_en = 1'b1;
        fork
            begin
                while (rand_ready_en) begin
                    @(posedge clk);
                    #2;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join_none
        for (int n = 0; n < 40; n++) begin
            send(2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31)), 1'b1);
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 4));
        end
        rand_ready_en = 1'b0;
        tick(2);
        wait_drain();

        // Reset while a SQRT is waiting
        mul_delay = 50;
        send(FPU_SQRT, 32'h4000, 32'h0, 5'd9, 1'b0);
        tick(4);
        check("rstw_fpu_opc", 32'(fpu_operation), 32'(FPU_SQRT));
        #2;
        reset = 1'b0;
        #1;
        check("rstw_out_valid", 32'(out_valid), 32'd0);
        check("rstw_fpu_op1", fpu_operand_1, 32'd0);
        check("rstw_fpu_opc", 32'(fpu_operation), 32'd0);
        check("rstw_busy", 32'(busy), 32'd0);
        check("rstw_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        tick(30);
        check("rstw_busy_after", 32'(busy), 32'd0);
        check("rstw_valid_after", 32'(out_valid), 32'd0);

        // FPU that never becomes ready
        never_ready = 1'b1;
        mul_delay   = 0;
`ifdef FPU_DISPATCH_TIMEOUT_EN
        begin
            exp_t e;
            send(FPU_MUL, 32'h800, 32'h800, 5'd7, 1'b0);
            e.res = 32'hFFFF_FFFF;
            e.tag = 5'd7;
            e.err = 1'b1;
            q.push_back(e);
            tick(9);
            check("tmo_valid_early", 32'(out_valid), 32'd0);
            tick(1);
            check("tmo_valid", 32'(out_valid), 32'd1);
            check("tmo_error", 32'(out_error), 32'd1);
            wait_drain();
            check("tmo_error_clear", 32'(out_error), 32'd0);
        end
`else
        send(FPU_MUL, 32'h800, 32'h800, 5'd7, 1'b0);
        tick(100);
        check("notmo_valid", 32'(out_valid), 32'd0);
        check("notmo_error", 32'(out_error), 32'd0);
        check("notmo_busy", 32'(busy), 32'd1);
        check("notmo_fpu_opc", 32'(fpu_operation), 32'(FPU_MUL));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick(2);
`endif
        never_ready = 1'b0;

        check("final_queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fpu_dispatch_unit.md
Name: fpu_dispatch_unit

Overview:
- Issue stage directly upstream of the fixed-point unit.
- Accepts tagged operation requests from decode over a valid/ready handshake and buffers them in a small FIFO.
- Drives one operation at a time into the FPU, holds the operands stable until the FPU's ready is sampled, then registers the result with its tag for writeback over a second valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width; matches FPU WIDTH.
- TAG_W, 5, destination-register tag width.
- DEPTH, 2, input FIFO entries (power of two, ≥2).
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit (used only with the optional feature).

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready at a clock edge.
- in_operation  in  2  `FPU_ADD / `FPU_SUB / `FPU_MUL / `FPU_SQRT code.
- in_operand_1  in  WIDTH  first operand, Q(WIDTH-FBITS).FBITS.
- in_operand_2  in  WIDTH  second operand; ignored for SQRT.
- in_tag  in  TAG_W  destination tag.
- fpu_operand_1  out  WIDTH  registered, to FPU operand_1.
- fpu_operand_2  out  WIDTH  registered, to FPU operand_2.
- fpu_operation  out  2  registered, to FPU operation.
- fpu_result  in  WIDTH  from FPU result.
- fpu_ready  in  1  from FPU ready.
- out_valid  out  1  result valid.
- out_ready  in  1  writeback accepts.
- out_result  out  WIDTH  captured result.
- out_tag  out  TAG_W  tag of captured result.
- out_error  out  1  timeout flag; tied 0 without the optional feature.
- busy  out  1  high when the FIFO is non-empty or the state is not IDLE.

Behaviour:
- Reset (reset=0, async):
  - FIFO emptied, both pointers 0.
  - State IDLE.
  - fpu_operand_1/2 = 0, fpu_operation = 0.
  - out_valid = 0, out_result = 0, out_tag = 0, out_error = 0.
  - in_ready = 1 on the first cycle after deassertion.
  - Reset mid-operation discards all queued and in-flight work; no output appears.
- FIFO:
  - in_ready = !full, derived from registered state only; no same-cycle pop-through.
  - Push on in_valid & in_ready.
  - Read/write pointers are log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty on wrap-around.
  - Push when full cannot occur, because in_ready=0.
- State machine:
  - IDLE: FIFO non-empty -> pop head into fpu_* registers and latch tag; go to ISSUE.
  - ISSUE: exactly one settle cycle so the FPU's ready reflects the new operation, not the previous one (stale product/root ready); go to WAIT.
  - WAIT: sample fpu_ready each edge. If 1, capture out_result = fpu_result and out_tag, set out_valid=1, go to DONE. Otherwise stay; fpu_* held stable.
  - DONE: out_valid=1; out_result/out_tag held while out_ready=0. On out_valid & out_ready: if FIFO non-empty, pop the next entry and go to ISSUE in the same edge (out_valid falls); else go to IDLE.
- Latency:
  - Request accepted at edge E into an empty, IDLE unit: fpu_* driven after E+1; out_valid high after E+3 when fpu_ready is already 1 in WAIT (ADD/SUB).
  - MUL/SQRT: out_valid rises one edge after the first WAIT-cycle edge at which fpu_ready=1.
  - Throughput: one ADD/SUB per 3 cycles with out_ready held 1.
- Arithmetic: none in this block; operands and result pass through bit-exact.
- The FPU tristate default ('bz) is never selected, since all four operation codes are valid.
- Simultaneous push to the FIFO and pop by the FSM in one edge is legal; occupancy is unchanged.

Optional Feature:
- Macro: FPU_DISPATCH_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with fpu_ready still 0, go to DONE with out_result = all-ones, out_error=1, and out_tag = the in-flight tag.
  - out_error clears with the out handshake.
- Undefined: no counter; WAIT persists indefinitely; out_error tied 0.

Decomposition:
- Shared defines header (Defines.vh) keeps the `FPU_ADD/`FPU_SUB/`FPU_MUL/`FPU_SQRT codes.
- Add to the same header:
  - state encodings FPD_IDLE=2'd0, FPD_ISSUE=2'd1, FPD_WAIT=2'd2, FPD_DONE=2'd3.
  - default TIMEOUT_CYCLES.
- One sub-module: fpu_dispatch_fifo (parameterised WIDTH*2+2+TAG_W payload, DEPTH, full/empty, async active-low reset).

Test Plan:
- All scenarios use an FPU behavioural model with FBITS=10 and configurable MUL/SQRT ready delay.
- ADD: in 0x600 + 0x900, tag 3, out_ready=1 -> out_valid after E+3, out_result 0xF00, out_tag 3, fpu_operation=`FPU_ADD during ISSUE/WAIT.
- MUL with model ready delay 5: 0x800 × 0xC00 (2.0×3.0) -> out_result 0x1800 exactly once, after fpu_ready rises. Prior stale ready=1 must not be captured.
- Backpressure: three SUB requests back-to-back, out_ready=0 for 10 cycles:
  - in_ready drops after two accepted requests (DEPTH=2), with one op held in DONE.
  - Releasing out_ready yields results in order, tags 1,2,3, with no loss or duplication across FIFO pointer wrap.
- Reset mid-WAIT: assert reset=0 during a SQRT -> out_valid, fpu_* and FIFO cleared immediately (async). After release, no stale result appears and busy=0.
- Timeout (FPU_DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, model never readies) -> out_valid with out_result 0xFFFFFFFF and out_error=1 after 8 WAIT cycles. Without the macro, still waiting at cycle 100 and out_error=0.
